// File: rtl/seg7_count_display_if.sv
// Bundle between the hex up/down counter and its 7-segment display stage.
// No handshake: count_in and the control switches are sampled on every clk_2 edge.
interface seg7_count_display_if #(
    parameter int NBITS_COUNT = 4,
    parameter int NBITS_TOP   = 8
);
    logic [NBITS_COUNT-1:0] count_in;
    logic                   counter_on;
    logic                   counter_up;
    logic                   load;
    logic                   blank;
    logic [NBITS_TOP-1:0]   SEG;
    logic                   digit_changed;
    logic [NBITS_TOP-1:0]   wrap_total;

    modport master (
        output count_in, counter_on, counter_up, load, blank,
        input  SEG, digit_changed, wrap_total
    );

    modport slave (
        input  count_in, counter_on, counter_up, load, blank,
        output SEG, digit_changed, wrap_total
    );
endinterface

// File: rtl/seg7_count_display.sv
// Display stage for the hex counter: registered 7-segment decode, wrap-triggered
// decimal-point flash, saturating wrap count and a digit-change pulse.
module seg7_count_display #(
    parameter int NBITS_COUNT = 4,
    parameter int NBITS_TOP   = 8,
    parameter int DP_CYCLES   = 4
) (
    input  logic                               clk_2,
    input  logic                               reset_n,
    seg7_count_display_if.slave                bus,
    output logic [$clog2(DP_CYCLES+1)-1:0]     dbg_dp_timer,
    output logic                               dbg_primed
);

    localparam int TIMER_W = $clog2(DP_CYCLES + 1);
    localparam logic [TIMER_W-1:0]     DP_LOAD   = TIMER_W'(DP_CYCLES);
    localparam logic [TIMER_W-1:0]     DP_ONE    = TIMER_W'(1);
    localparam logic [NBITS_COUNT-1:0] CNT_MAX   = '1;
    localparam logic [NBITS_COUNT-1:0] CNT_MIN   = '0;
    localparam logic [NBITS_TOP-1:0]   TOTAL_MAX = '1;

    logic [NBITS_COUNT-1:0] prev;
    logic                   primed;
    logic [TIMER_W-1:0]     dp_timer;

    logic                   up_wrap;
    logic                   down_wrap;
    logic                   is_wrap;
    logic                   dp_lit;
    logic [NBITS_TOP-1:0]   seg_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        up_wrap   = bus.counter_up  && (prev == CNT_MAX) && (bus.count_in == CNT_MIN);
        down_wrap = !bus.counter_up && (prev == CNT_MIN) && (bus.count_in == CNT_MAX);
        is_wrap   = primed && bus.counter_on && !bus.load && (up_wrap || down_wrap);
        // dp_timer holds the lit cycles still owed including the one on display,
        // so the last count (1) is the cycle where DP goes dark.
        dp_lit    = is_wrap || (dp_timer > DP_ONE);
        seg_next  = '0;
        if (!bus.blank) begin
            seg_next[6:0] = hex_decode(bus.count_in);
            seg_next[7]   = dp_lit;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            bus.SEG           <= '0;
            bus.digit_changed <= 1'b0;
            bus.wrap_total    <= '0;
            dp_timer          <= '0;
            prev              <= '0;
            primed            <= 1'b0;
        end else begin
            bus.SEG           <= seg_next;
            bus.digit_changed <= primed && (bus.count_in != prev);
            prev              <= bus.count_in;
            primed            <= 1'b1;
            if (is_wrap) begin
                dp_timer <= DP_LOAD;
            end else if (dp_timer != '0) begin
                dp_timer <= dp_timer - DP_ONE;
            end
            if (is_wrap && (bus.wrap_total != TOTAL_MAX)) begin
                bus.wrap_total <= bus.wrap_total + 1'b1;
            end
        end
    end

    assign dbg_dp_timer = dp_timer;
    assign dbg_primed   = primed;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display: decode table, wrap DP flash and
// retrigger, load suppression, wrap saturation, blanking and async reset.
module tb_seg7_count_display;

  logic       clk_2;
  logic       reset_n;
  logic [2:0] dbg_dp_timer;
  logic       dbg_primed;

  int n_tests;
  int n_fail;

  logic [6:0] seg_tbl [16];
  logic [7:0] exp_q [$];

  seg7_count_display_if #(.NBITS_COUNT(4), .NBITS_TOP(8)) bus ();

  seg7_count_display #(
    .NBITS_COUNT(4),
    .NBITS_TOP  (8),
    .DP_CYCLES  (4)
  ) dut (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_dp_timer(dbg_dp_timer),
    .dbg_primed  (dbg_primed)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.count_in   = 4'h0;
    bus.counter_on = 1'b0;
    bus.counter_up = 1'b1;
    bus.load       = 1'b0;
    bus.blank      = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (bus.SEG !== 8'h00) begin
      n_fail++; $display("FAIL reset_seg got %h exp 00", bus.SEG);
    end
    n_tests++;
    if (bus.digit_changed !== 1'b0) begin
      n_fail++; $display("FAIL reset_changed got %b exp 0", bus.digit_changed);
    end
    n_tests++;
    if (bus.wrap_total !== 8'h00) begin
      n_fail++; $display("FAIL reset_wrap_total got %h exp 00", bus.wrap_total);
    end
    n_tests++;
    if (dbg_primed !== 1'b0) begin
      n_fail++; $display("FAIL reset_primed got %b exp 0", dbg_primed);
    end
    reset_n = 1'b1;
  endtask

  // Count 0..F upward; the first edge only primes, later edges each change the digit.
  task automatic test_decode();
    logic [7:0] exp;
    bus.counter_on = 1'b1;
    bus.counter_up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.count_in = 4'(i);
      exp_q.push_back({1'b0, seg_tbl[i]});
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (bus.SEG !== exp) begin
        n_fail++; $display("FAIL decode_seg[%0d] got %h exp %h", i, bus.SEG, exp);
      end
      n_tests++;
      if (bus.digit_changed !== (i != 0)) begin
        n_fail++; $display("FAIL decode_changed[%0d] got %b exp %b", i, bus.digit_changed, (i != 0));
      end
    end
    n_tests++;
    if (bus.wrap_total !== 8'h00) begin
      n_fail++; $display("FAIL decode_wrap_total got %h exp 00", bus.wrap_total);
    end
  endtask

  task automatic test_load_no_wrap();
    bus.count_in = 4'h0;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    n_tests++;
    if (bus.SEG !== 8'h3F) begin
      n_fail++; $display("FAIL load_seg got %h exp 3F", bus.SEG);
    end
    n_tests++;
    if (bus.digit_changed !== 1'b1) begin
      n_fail++; $display("FAIL load_changed got %b exp 1", bus.digit_changed);
    end
    n_tests++;
    if (bus.wrap_total !== 8'h00) begin
      n_fail++; $display("FAIL load_wrap_total got %h exp 00", bus.wrap_total);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (bus.SEG !== 8'h3F) begin
        n_fail++; $display("FAIL load_hold_seg[%0d] got %h exp 3F", c, bus.SEG);
      end
    end
  endtask

  task automatic test_up_wrap();
    bus.count_in = 4'hF;
    tick();
    n_tests++;
    if (bus.SEG !== 8'h71) begin
      n_fail++; $display("FAIL up_pre_seg got %h exp 71", bus.SEG);
    end
    bus.count_in = 4'h0;
    tick();
    n_tests++;
    if (bus.SEG !== 8'hBF) begin
      n_fail++; $display("FAIL up_wrap_seg got %h exp BF", bus.SEG);
    end
    n_tests++;
    if (bus.wrap_total !== 8'h01) begin
      n_fail++; $display("FAIL up_wrap_total got %h exp 01", bus.wrap_total);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_tests++;
      if (bus.SEG !== ((c < 4) ? 8'hBF : 8'h3F)) begin
        n_fail++; $display("FAIL up_dp_seg[%0d] got %h exp %h", c, bus.SEG, (c < 4) ? 8'hBF : 8'h3F);
      end
    end
  endtask

  // Down wrap 0->F, reload to 0, second down wrap two edges after the first.
  task automatic test_down_retrigger();
    logic [7:0] exp_hold [5];
    int dp_high;
    exp_hold = '{8'hF1, 8'hF1, 8'hF1, 8'h71, 8'h71};
    dp_high = 0;
    bus.counter_up = 1'b0;
    bus.count_in   = 4'hF;
    tick();
    if (bus.SEG[7]) dp_high++;
    n_tests++;
    if (bus.SEG !== 8'hF1 || bus.wrap_total !== 8'h02) begin
      n_fail++; $display("FAIL down_wrap1 got seg %h total %h exp F1 02", bus.SEG, bus.wrap_total);
    end
    bus.load     = 1'b1;
    bus.count_in = 4'h0;
    tick();
    if (bus.SEG[7]) dp_high++;
    n_tests++;
    if (bus.SEG !== 8'hBF || bus.wrap_total !== 8'h02) begin
      n_fail++; $display("FAIL down_load got seg %h total %h exp BF 02", bus.SEG, bus.wrap_total);
    end
    bus.load     = 1'b0;
    bus.count_in = 4'hF;
    tick();
    if (bus.SEG[7]) dp_high++;
    n_tests++;
    if (bus.SEG !== 8'hF1 || bus.wrap_total !== 8'h03) begin
      n_fail++; $display("FAIL down_wrap2 got seg %h total %h exp F1 03", bus.SEG, bus.wrap_total);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.SEG[7]) dp_high++;
      n_tests++;
      if (bus.SEG !== exp_hold[c]) begin
        n_fail++; $display("FAIL down_hold_seg[%0d] got %h exp %h", c, bus.SEG, exp_hold[c]);
      end
    end
    n_tests++;
    if (dp_high != 6) begin
      n_fail++; $display("FAIL down_dp_cycles got %0d exp 6", dp_high);
    end
  endtask

  task automatic test_saturation();
    bus.counter_up = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.count_in = 4'h0;
      tick();
      bus.count_in = 4'hF;
      tick();
      if (i == 99) begin
        n_tests++;
        if (bus.wrap_total !== 8'd103) begin
          n_fail++; $display("FAIL sat_mid_total got %0d exp 103", bus.wrap_total);
        end
      end
    end
    n_tests++;
    if (bus.wrap_total !== 8'hFF) begin
      n_fail++; $display("FAIL sat_total got %h exp FF", bus.wrap_total);
    end
    bus.blank = 1'b1;
    tick();
    n_tests++;
    if (bus.SEG !== 8'h00 || bus.wrap_total !== 8'hFF) begin
      n_fail++; $display("FAIL blank got seg %h total %h exp 00 FF", bus.SEG, bus.wrap_total);
    end
    bus.blank = 1'b0;
    tick();
    n_tests++;
    if (bus.SEG !== 8'hF1) begin
      n_fail++; $display("FAIL unblank_seg got %h exp F1", bus.SEG);
    end
    tick();
    n_tests++;
    if (bus.SEG !== 8'h71) begin
      n_fail++; $display("FAIL unblank_dp_end got %h exp 71", bus.SEG);
    end
  endtask

  task automatic test_reset_mid();
    bus.count_in = 4'h0;
    tick();
    n_tests++;
    if (bus.SEG !== 8'hBF) begin
      n_fail++; $display("FAIL rmid_pre_seg got %h exp BF", bus.SEG);
    end
    #2;
    reset_n      = 1'b0;
    bus.count_in = 4'hF;
    #1;
    n_tests++;
    if (bus.SEG !== 8'h00 || bus.wrap_total !== 8'h00 || bus.digit_changed !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got seg %h total %h chg %b exp 00 00 0",
                         bus.SEG, bus.wrap_total, bus.digit_changed);
    end
    tick();
    reset_n        = 1'b1;
    bus.counter_up = 1'b0;
    bus.count_in   = 4'hF;
    tick();
    n_tests++;
    if (bus.SEG !== 8'h71 || bus.wrap_total !== 8'h00 || bus.digit_changed !== 1'b0) begin
      n_fail++; $display("FAIL rmid_prime got seg %h total %h chg %b exp 71 00 0",
                         bus.SEG, bus.wrap_total, bus.digit_changed);
    end
    bus.counter_up = 1'b1;
    bus.count_in   = 4'h0;
    tick();
    n_tests++;
    if (bus.SEG !== 8'hBF || bus.wrap_total !== 8'h01 || bus.digit_changed !== 1'b1) begin
      n_fail++; $display("FAIL rmid_rewrap got seg %h total %h chg %b exp BF 01 1",
                         bus.SEG, bus.wrap_total, bus.digit_changed);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_decode();
    test_load_no_wrap();
    test_up_wrap();
    test_down_retrigger();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
